// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier controller that borrows an
// external 8-bit adder, one partial product per RUN cycle over four cycles.
module shift_add_mult_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] add_x,
  output logic [7:0] add_y,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic [7:0] product,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] acc_q;
  logic [7:0] mcand_q;
  logic [3:0] mplier_q;
  logic [1:0] count_q;
  logic [7:0] product_q;
  logic       busy_q;
  logic       done_q;
  logic       ovf_q;
  logic [7:0] add_x_d;
  logic [7:0] add_y_d;

  // The adder is only used while RUN; otherwise its operands are held at zero.
  always_comb begin
    add_x_d = 8'h00;
    add_y_d = 8'h00;
    if (state_q == RUN) begin
      add_x_d = acc_q;
      add_y_d = mplier_q[0] ? mcand_q : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= 8'h00;
      mcand_q   <= 8'h00;
      mplier_q  <= 4'h0;
      count_q   <= 2'd0;
      product_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {4'b0000, a};
            mplier_q <= b;
            acc_q    <= 8'h00;
            count_q  <= 2'd0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= add_sum;
          mcand_q  <= {mcand_q[6:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[3:1]};
          count_q  <= count_q + 2'd1;
          if (add_cout) begin
            ovf_q <= 1'b1;
          end
          // Last partial product: the adder output is already the full result.
          if (count_q == 2'd3) begin
            product_q <= add_sum;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign add_x   = add_x_d;
  assign add_y   = add_y_d;
  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a behavioural ripple-adder stub
// whose carry-out can be forced high on a chosen RUN cycle.
module tb_shift_add_mult_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] add_x;
  logic [7:0] add_y;
  logic [7:0] add_sum;
  logic       add_cout;
  logic [7:0] product;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       force_cout;
  logic       raw_cout;

  int tests_run;
  int tests_failed;

  shift_add_mult_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .add_x   (add_x),
    .add_y   (add_y),
    .add_sum (add_sum),
    .add_cout(add_cout),
    .product (product),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  assign {raw_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y};
  assign add_cout = raw_cout | force_cout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One multiply, driven and sampled on falling edges. force_idx selects the
  // RUN cycle (0..3) on which the adder stub reports a carry; 7 means never.
  // mid_start re-asserts start with new operands during RUN and DONE.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic [7:0] exp_p, input int force_idx,
                       input bit mid_start);
    logic [7:0] exp_x;
    logic [7:0] exp_y;
    logic [7:0] mc;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    @(negedge clk);
    start = mid_start;
    exp_x = 8'h00;
    mc = {4'b0000, ta};
    for (int i = 0; i < 4; i++) begin
      if (mid_start) begin
        a = 4'd1; b = 4'd1;
      end else begin
        a = ~ta; b = ~tb_v;
      end
      force_cout = (i == force_idx);
      exp_y = tb_v[i] ? mc : 8'h00;
      $display("[TB] op %0d*%0d cycle %0d: add_x=%0d add_y=%0d", ta, tb_v, i, add_x, add_y);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_add_x", add_x, exp_x);
      check("run_add_y", add_y, exp_y);
      check("run_ovf", ovf, (force_idx < i) ? 1 : 0);
      exp_x = exp_x + exp_y;
      mc = mc << 1;
      @(negedge clk);
    end
    force_cout = 1'b0;
    $display("[TB] op %0d*%0d done=%0d product=%0d ovf=%0d", ta, tb_v, done, product, ovf);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_product", product, exp_p);
    check("done_ovf", ovf, (force_idx < 4) ? 1 : 0);
    check("done_add_y", add_y, 0);
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_product", product, exp_p);
    check("idle_ovf", ovf, (force_idx < 4) ? 1 : 0);
    check("idle_add_x", add_x, 0);
    @(negedge clk);
    check("idle_hold_busy", busy, 0);
    check("idle_hold_product", product, exp_p);
  endtask

  initial begin
    int done_cnt;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; start = 1'b1; a = 4'd5; b = 4'd5; force_cout = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset: busy=%0d done=%0d product=%0d ovf=%0d", busy, done, product, ovf);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_ovf", ovf, 0);
    check("rst_add_x", add_x, 0);
    check("rst_add_y", add_y, 0);
    rst = 1'b0; start = 1'b0;

    do_op(4'd15, 4'd15, 8'd225, 7, 1'b0);
    do_op(4'd13, 4'd11, 8'd143, 7, 1'b0);
    do_op(4'd0,  4'd7,  8'd0,   7, 1'b0);
    do_op(4'd9,  4'd0,  8'd0,   7, 1'b0);
    do_op(4'd6,  4'd7,  8'd42,  7, 1'b1);

    // Start held high: accepts every 6th edge and never in between.
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd5;
    done_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      $display("[TB] held start cycle %0d: done=%0d busy=%0d product=%0d", k, done, busy, product);
      check("held_done", done, (k % 6 == 5) ? 1 : 0);
      check("held_busy", busy, (k % 6 == 0) ? 0 : 1);
      if (k % 6 == 5) check("held_product", product, 15);
      if (done) done_cnt++;
    end
    start = 1'b0;
    check("held_done_count", done_cnt, 3);
    repeat (6) @(negedge clk);

    // Reset during the second RUN cycle aborts with no done pulse.
    start = 1'b1; a = 4'd7; b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] abort: busy=%0d done=%0d product=%0d", busy, done, product);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 0);
    do_op(4'd2, 4'd3, 8'd6, 7, 1'b0);

    // Forced carry on RUN cycle 1: sticky ovf, cleared by the next accept.
    do_op(4'd5, 4'd6, 8'd30, 1, 1'b0);
    do_op(4'd4, 4'd4, 8'd16, 7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
